grant_tenure_ctrl: RTL and testbench

Sits directly upstream of the priority/round-robin arbiter. It latches per-unit request pulses into held pending bits and drives the arbiter's request vector. It consumes the arbiter's registered one-hot grant, converts it into a bus tenure of a programmed beat count, and reports ownership and completion back to the requesting units.

---
 rtl/grant_tenure_ctrl.sv | 134 +++++++++++++
 tb/tb_grant_tenure_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_tenure_ctrl.sv
// Request holder and bus-tenure sequencer that sits in front of the arbiter.
// Latches request pulses, presents them to the arbiter, and turns a grant into a counted tenure.
module grant_tenure_ctrl #(
  parameter int NUMUNITS     = 9,
  parameter int ADDRESSWIDTH = 3,
  parameter int LENWIDTH     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMUNITS-1:0]          req_pulse,
  input  logic [NUMUNITS*LENWIDTH-1:0] req_len,
  input  logic [NUMUNITS-1:0]          grant,
  output logic [NUMUNITS-1:0]          request,
  output logic                         owner_valid,
  output logic [ADDRESSWIDTH-1:0]      owner_id,
  output logic                         owner_last,
  output logic [NUMUNITS-1:0]          done,
  output logic [NUMUNITS-1:0]          overrun,
  output logic                         busy,
  output logic [1:0]                   fsm_state
);
  localparam int IDXW = (NUMUNITS > 1) ? $clog2(NUMUNITS) : 1;

  // Encoding is visible on fsm_state: IDLE=0, ARB=1, OWN=2, REL=3.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUMUNITS-1:0] pending_q, pending_d;
  logic [LENWIDTH-1:0] len_q [NUMUNITS];
  logic [LENWIDTH-1:0] counter_q, counter_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [NUMUNITS-1:0] owner_mask;
  logic [NUMUNITS-1:0] accept;
  logic [NUMUNITS-1:0] sel;
  logic [NUMUNITS-1:0] sel_onehot;
  logic [IDXW-1:0]     sel_idx;
  logic [LENWIDTH-1:0] sel_len;

  // Owner identity only counts while the tenure is live; in REL the unit may queue again.
  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NUMUNITS; i++) begin
      owner_mask[i] = (state_q == OWN) && (owner_q == IDXW'(i));
    end
  end

  assign accept = req_pulse & ~pending_q & ~owner_mask;
  assign sel    = grant & pending_q;

  // Lowest set index of sel wins; grant bits without a pending request are ignored.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    sel_len    = '0;
    for (int i = NUMUNITS - 1; i >= 0; i--) begin
      if (sel[i]) begin
        sel_idx       = IDXW'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_len       = len_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    owner_d    = owner_q;
    pending_d  = pending_q | accept;
    owner_last = 1'b0;
    done       = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) state_d = ARB;
      end
      ARB: begin
        if (|sel) begin
          owner_d   = sel_idx;
          counter_d = sel_len;
          pending_d = (pending_q | accept) & ~sel_onehot;
          state_d   = OWN;
        end
      end
      OWN: begin
        if (counter_q == '0) begin
          owner_last = 1'b1;
          done       = owner_mask;
          state_d    = REL;
        end else begin
          counter_d = counter_q - LENWIDTH'(1);
        end
      end
      REL: begin
        // Wait out the arbiter's registered grant so it is not taken as a fresh one.
        if (grant == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      counter_q <= '0;
      owner_q   <= '0;
      overrun   <= '0;
      for (int i = 0; i < NUMUNITS; i++) len_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      counter_q <= counter_d;
      owner_q   <= owner_d;
      overrun   <= req_pulse & ~accept;
      for (int i = 0; i < NUMUNITS; i++) begin
        if (accept[i]) len_q[i] <= req_len[i*LENWIDTH +: LENWIDTH];
      end
    end
  end

  // Arbiter handshake: request[i] stays high from capture until unit i is selected in ARB;
  // the arbiter answers with a registered one-hot grant, and request is masked to 0 during OWN/REL.
  assign request     = ((state_q == IDLE) || (state_q == ARB)) ? pending_q : '0;
  assign owner_valid = (state_q == OWN);
  assign owner_id    = ADDRESSWIDTH'(owner_q);
  assign busy        = (state_q != IDLE);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_grant_tenure_ctrl.sv
// Bench for grant_tenure_ctrl: directed stimulus with a tenure/overrun scoreboard.
// The bench plays the arbiter by driving grant directly.
module tb_grant_tenure_ctrl;
  localparam int N  = 9;
  localparam int AW = 3;
  localparam int LW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic          clock;
  logic          reset;
  logic [N-1:0]  req_pulse;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]  grant;
  logic [N-1:0]  request;
  logic          owner_valid;
  logic [AW-1:0] owner_id;
  logic          owner_last;
  logic [N-1:0]  done;
  logic [N-1:0]  overrun;
  logic          busy;
  logic [1:0]    fsm_state;

  // Tenure entries are {id[15:8], beats[7:0]}; overrun entries are the expected vector.
  logic [15:0]  exp_q[$];
  logic [N-1:0] ovr_q[$];

  int checks = 0;
  int errors = 0;
  int run_len = 0;

  grant_tenure_ctrl #(.NUMUNITS(N), .ADDRESSWIDTH(AW), .LENWIDTH(LW)) dut (
    .clock(clock),
    .reset(reset),
    .req_pulse(req_pulse),
    .req_len(req_len),
    .grant(grant),
    .request(request),
    .owner_valid(owner_valid),
    .owner_id(owner_id),
    .owner_last(owner_last),
    .done(done),
    .overrun(overrun),
    .busy(busy),
    .fsm_state(fsm_state)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_len(input int unit, input int len);
    logic [LW-1:0] l;
    l = LW'(len);
    req_len[unit*LW +: LW] = l;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    req_pulse = mask;
    tick();
    req_pulse = '0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (fsm_state != s && n < budget) begin
      tick();
      n++;
    end
    check(name, fsm_state, s);
  endtask

  task automatic wait_last(input int budget, input string name);
    int n;
    n = 0;
    while (!owner_last && n < budget) begin
      tick();
      n++;
    end
    check(name, owner_last, 1);
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  always @(negedge clock) begin
    logic [15:0] e;
    logic [N-1:0] one;
    if (!reset) begin
      run_len = 0;
    end else begin
      if (owner_valid) begin
        run_len++;
        check("request_low_in_own", request, 0);
        if (owner_last) begin
          if (exp_q.size() == 0) begin
            check("tenure_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            one = N'(1);
            check("tenure_id", owner_id, e[15:8]);
            check("tenure_beats", run_len, e[7:0]);
            check("done_vec", done, one << e[15:8]);
          end
          run_len = 0;
        end
      end else begin
        check("no_stray_done", {owner_last, done}, 0);
      end
      if (overrun != '0) begin
        if (ovr_q.size() == 0) check("overrun_unexpected", overrun, 0);
        else check("overrun_vec", overrun, ovr_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0;
    req_pulse = '1;
    req_len = '0;
    grant = '0;

    // Reset held with all request pulses high
    repeat (3) tick();
    check("rst_request", request, 0);
    check("rst_owner_valid", owner_valid, 0);
    check("rst_owner_id", owner_id, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    req_pulse = '0;
    tick();
    tick();
    check("rst_pending_empty", request, 0);
    check("rst_still_idle", fsm_state, S_IDLE);

    // Single unit, len=3, owner re-requests in its done cycle
    set_len(2, 3);
    pulse(9'h004);
    check("single_request", request, 9'h004);
    check("single_idle", fsm_state, S_IDLE);
    tick();
    check("single_arb", fsm_state, S_ARB);
    grant = 9'h004;
    exp_q.push_back({8'd2, 8'd4});
    tick();
    check("single_owner_valid", owner_valid, 1);
    check("single_owner_id", owner_id, 2);
    check("single_busy", busy, 1);
    wait_last(8, "single_last");
    ovr_q.push_back(9'h004);
    pulse(9'h004);
    check("single_rel", fsm_state, S_REL);
    tick();
    check("single_rel_hold", fsm_state, S_REL);
    grant = '0;
    tick();
    check("single_back_idle", busy, 0);
    check("single_no_requeue", request, 0);

    // Queued units 1 and 5, plus a same-cycle drop and a mid-tenure capture
    set_len(1, 0);
    set_len(5, 1);
    pulse(9'h022);
    check("queue_request", request, 9'h022);
    tick();
    check("queue_arb", fsm_state, S_ARB);
    grant = 9'h020;
    exp_q.push_back({8'd5, 8'd2});
    ovr_q.push_back(9'h020);
    pulse(9'h020);
    check("queue_own5", owner_id, 5);
    set_len(7, 2);
    pulse(9'h080);
    wait_state(S_REL, 8, "queue_rel5");
    grant = '0;
    wait_state(S_ARB, 4, "queue_arb2");
    check("queue_request2", request, 9'h082);
    grant = 9'h002;
    exp_q.push_back({8'd1, 8'd1});
    wait_state(S_REL, 6, "queue_rel1");
    grant = '0;
    wait_state(S_ARB, 4, "queue_arb3");
    check("queue_request3", request, 9'h080);
    grant = 9'h080;
    exp_q.push_back({8'd7, 8'd3});
    wait_state(S_REL, 8, "queue_rel7");
    grant = '0;
    wait_state(S_IDLE, 4, "queue_idle");

    // Overrun: second pulse while pending keeps the first length
    set_len(4, 6);
    pulse(9'h010);
    tick();
    set_len(4, 9);
    ovr_q.push_back(9'h010);
    pulse(9'h010);
    grant = 9'h010;
    exp_q.push_back({8'd4, 8'd7});
    wait_state(S_REL, 12, "ovr_rel");
    grant = '0;
    wait_state(S_IDLE, 4, "ovr_idle");
    check("ovr_request_clear", request, 0);

    // Spurious grant to a non-pending unit
    set_len(3, 2);
    pulse(9'h008);
    tick();
    grant = 9'h040;
    repeat (3) tick();
    check("spur_stays_arb", fsm_state, S_ARB);
    check("spur_no_owner", owner_valid, 0);
    check("spur_request", request, 9'h008);
    grant = 9'h048;
    exp_q.push_back({8'd3, 8'd3});
    tick();
    check("spur_owner_id", owner_id, 3);
    wait_state(S_REL, 8, "spur_rel");
    grant = '0;
    wait_state(S_IDLE, 4, "spur_idle");

    // Reset during the second cycle of a len=7 tenure
    set_len(0, 7);
    pulse(9'h001);
    tick();
    grant = 9'h001;
    tick();
    check("mid_own", owner_valid, 1);
    set_len(8, 1);
    pulse(9'h100);
    check("mid_still_own", owner_valid, 1);
    reset = 1'b0;
    tick();
    check("mid_owner_valid", owner_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_last", owner_last, 0);
    check("mid_request", request, 0);
    reset = 1'b1;
    grant = '0;
    tick();
    tick();
    check("mid_pending_cleared", request, 0);
    check("mid_idle", busy, 0);

    repeat (2) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("ovr_q_drained", ovr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
